// File: rtl/ext_bus_ctrl.sv
// External 16-bit multiplexed address/data bus controller.
// Runs one request at a time: address latch phases, then a timed read wait or a write strobe.
module ext_bus_ctrl #(
   parameter int WAIT_CYCLES = 2,
   parameter int WE_CYCLES   = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [15:0] req_wdata,
   input  logic [1:0]  req_be,
   output logic        resp_valid,
   output logic [15:0] resp_rdata,
   output logic        resp_err,
   output logic [15:0] bus_dout,
   input  logic [15:0] bus_din,
   output logic        bus_oe,
   output logic [1:0]  bus_le,
   output logic        bus_bhe_n,
   output logic        bus_we_n
);

   typedef enum logic [2:0] {
      IDLE, LAT_LO, LAT_HI, RD_WAIT, WR_SETUP, WR_STROBE, WR_HOLD, DONE
   } state_t;

   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);
   localparam logic [3:0] WE_LOAD   = 4'(WE_CYCLES - 1);

   state_t      state;
   logic [3:0]  cnt;
   logic        write_q;
   logic [15:0] addr_lo;
   logic [13:0] addr_hi;
   logic [15:0] wdata_q;
   logic [1:0]  be_q;

   // Address bit 31 is replaced by the low-byte enable and bit 29 is forced to 0 on the bus.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{req_addr[31], req_addr[29]};

   // Every output is a flop loaded together with the state it belongs to.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= 4'd0;
         write_q    <= 1'b0;
         addr_lo    <= 16'd0;
         addr_hi    <= 14'd0;
         wdata_q    <= 16'd0;
         be_q       <= 2'b00;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_rdata <= 16'd0;
         resp_err   <= 1'b0;
         bus_dout   <= 16'd0;
         bus_oe     <= 1'b0;
         bus_le     <= 2'b00;
         bus_bhe_n  <= 1'b1;
         bus_we_n   <= 1'b1;
      end else begin
         resp_valid <= 1'b0;
         bus_le     <= 2'b00;
         bus_we_n   <= 1'b1;
         case (state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  write_q   <= req_write;
                  addr_lo   <= req_addr[15:0];
                  addr_hi   <= {req_addr[30], req_addr[28:16]};
                  wdata_q   <= req_wdata;
                  be_q      <= req_be;
                  req_ready <= 1'b0;
                  cnt       <= 4'd0;
                  if (req_be == 2'b00) begin
                     state      <= DONE;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                     bus_oe     <= 1'b0;
                  end else begin
                     state    <= LAT_LO;
                     resp_err <= 1'b0;
                     bus_dout <= req_addr[15:0];
                     bus_le   <= 2'b01;
                     bus_oe   <= 1'b1;
                  end
               end
            end
            LAT_LO: begin
               state     <= LAT_HI;
               cnt       <= 4'd0;
               bus_dout  <= {~be_q[0], addr_hi[13], 1'b0, addr_hi[12:0]};
               bus_le    <= 2'b10;
               bus_oe    <= 1'b1;
               bus_bhe_n <= ~be_q[1];
            end
            LAT_HI: begin
               if (write_q) begin
                  state    <= WR_SETUP;
                  cnt      <= 4'd0;
                  bus_dout <= wdata_q;
                  bus_oe   <= 1'b1;
               end else begin
                  state  <= RD_WAIT;
                  cnt    <= WAIT_LOAD;
                  bus_oe <= 1'b0;
               end
            end
            RD_WAIT: begin
               if (cnt == 4'd0) begin
                  state      <= DONE;
                  resp_rdata <= bus_din;
                  resp_valid <= 1'b1;
                  bus_bhe_n  <= 1'b1;
                  bus_oe     <= 1'b0;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            WR_SETUP: begin
               state    <= WR_STROBE;
               cnt      <= WE_LOAD;
               bus_we_n <= 1'b0;
            end
            WR_STROBE: begin
               if (cnt == 4'd0) begin
                  state <= WR_HOLD;
               end else begin
                  cnt      <= cnt - 4'd1;
                  bus_we_n <= 1'b0;
               end
            end
            WR_HOLD: begin
               state      <= DONE;
               cnt        <= 4'd0;
               resp_valid <= 1'b1;
               bus_oe     <= 1'b0;
               bus_bhe_n  <= 1'b1;
            end
            DONE: begin
               state     <= IDLE;
               cnt       <= 4'd0;
               req_ready <= 1'b1;
            end
            default: begin
               state     <= IDLE;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule
